// File: rtl/seven_segment_display_scheduler.sv
// Shares a 4-digit seven-segment display between three 16-bit sources: rotation on a dwell
// timer, source-0 pre-emption, and hex or saturated-decimal conversion into 5-bit glyph codes.
module seven_segment_display_scheduler #(
   parameter logic [23:0] DWELL_CYCLES  = 24'd12_000_000,
   parameter logic [23:0] UPDATE_CYCLES = 24'd1_200_000
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [15:0] src_value0,
   input  logic [15:0] src_value1,
   input  logic [15:0] src_value2,
   input  logic [2:0]  src_enable,
   input  logic [2:0]  src_decimal,
   input  logic        pri_req,
   output logic [19:0] digit,
   output logic        zero_fill,
   output logic [1:0]  active_src,
   output logic        busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_CONVERT = 3'd2;
   localparam logic [2:0] S_COMMIT  = 3'd3;
   localparam logic [2:0] S_DWELL   = 3'd4;

   localparam logic [23:0] DWELL_LAST  = DWELL_CYCLES - 24'd1;
   localparam logic [23:0] UPDATE_LAST = UPDATE_CYCLES - 24'd1;
   localparam logic [4:0]  SAT_CODE    = 5'b11001;

   logic [2:0]  state_q, state_d;
   logic [1:0]  active_src_q, active_src_d;
   logic [1:0]  sel_src_q, sel_src_d;
   logic        first_sel_q, first_sel_d;
   logic [23:0] dwell_cnt_q, dwell_cnt_d;
   logic [23:0] update_cnt_q, update_cnt_d;
   logic [19:0] digit_q, digit_d;
   logic        zero_fill_q, zero_fill_d;
   logic        busy_q, busy_d;
   logic [15:0] cap_val_q, cap_val_d;
   logic        cap_dec_q, cap_dec_d;
   logic [15:0] bcd_q, bcd_d;
   logic [15:0] shf_q, shf_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        pri_q;
   logic        reload_q, reload_d;
   logic        pend_rot_q, pend_rot_d;

   function automatic logic [1:0] mod3(input logic [2:0] x);
      logic [2:0] r;
      r = (x >= 3'd3) ? x - 3'd3 : x;
      return r[1:0];
   endfunction

   // Candidate order: inclusive of the current source only on the very first selection.
   logic [1:0] cand [3];
   for (genvar gi = 0; gi < 3; gi++) begin : g_cand
      assign cand[gi] = mod3({1'b0, active_src_q} + 3'(gi) + {2'b00, ~first_sel_q});
   end

   logic [1:0] pick_src;
   logic       pick_found;
   always_comb begin
      pick_src   = 2'd0;
      pick_found = 1'b0;
      if (pri_req) begin
         pick_found = 1'b1;
      end else begin
         for (int k = 2; k >= 0; k--) begin
            if (src_enable[cand[k]]) begin
               pick_found = 1'b1;
               pick_src   = cand[k];
            end
         end
      end
   end

   logic [15:0] sel_val;
   logic        sel_dec;
   always_comb begin
      case (sel_src_q)
         2'd1:    begin sel_val = src_value1; sel_dec = src_decimal[1]; end
         2'd2:    begin sel_val = src_value2; sel_dec = src_decimal[2]; end
         default: begin sel_val = src_value0; sel_dec = src_decimal[0]; end
      endcase
   end

   logic [15:0] bcd_adj;
   logic [19:0] page_hex, page_dec;
   logic        dec_sat;
   assign dec_sat = cap_val_q > 16'd9999;
   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign bcd_adj[gi*4 +: 4]  = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                             : bcd_q[gi*4 +: 4];
      assign page_hex[gi*5 +: 5] = {1'b0, cap_val_q[gi*4 +: 4]};
      assign page_dec[gi*5 +: 5] = dec_sat ? SAT_CODE : {1'b0, bcd_q[gi*4 +: 4]};
   end

   logic        dwell_last, update_last, pri_rise, pri_fall;
   logic [23:0] dwell_inc;
   assign dwell_last  = dwell_cnt_q == DWELL_LAST;
   assign update_last = update_cnt_q == UPDATE_LAST;
   assign dwell_inc   = dwell_last ? dwell_cnt_q : dwell_cnt_q + 24'd1;
   assign pri_rise    = pri_req & ~pri_q;
   assign pri_fall    = ~pri_req & pri_q;

   always_comb begin
      state_d      = state_q;
      active_src_d = active_src_q;
      sel_src_d    = sel_src_q;
      first_sel_d  = first_sel_q;
      dwell_cnt_d  = dwell_cnt_q;
      update_cnt_d = update_cnt_q;
      digit_d      = digit_q;
      zero_fill_d  = zero_fill_q;
      cap_val_d    = cap_val_q;
      cap_dec_d    = cap_dec_q;
      bcd_d        = bcd_q;
      shf_d        = shf_q;
      bit_cnt_d    = bit_cnt_q;
      reload_d     = reload_q;
      pend_rot_d   = pend_rot_q;

      if (pri_rise && state_q != S_IDLE && sel_src_q != 2'd0) begin
         // Pre-emption abandons whatever page was in flight; the display keeps the old page.
         state_d      = S_LOAD;
         sel_src_d    = 2'd0;
         reload_d     = 1'b0;
         pend_rot_d   = 1'b0;
         dwell_cnt_d  = '0;
         update_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_found) begin
                  sel_src_d   = pick_src;
                  first_sel_d = 1'b0;
                  reload_d    = 1'b0;
                  state_d     = S_LOAD;
               end else begin
                  digit_d     = '0;
                  zero_fill_d = 1'b0;
               end
            end
            S_LOAD: begin
               cap_val_d    = sel_val;
               cap_dec_d    = sel_dec;
               active_src_d = sel_src_q;
               bcd_d        = '0;
               shf_d        = sel_val;
               bit_cnt_d    = '0;
               state_d      = sel_dec ? S_CONVERT : S_COMMIT;
               if (reload_q) begin
                  dwell_cnt_d = dwell_inc;
                  if (dwell_last && !pri_req) pend_rot_d = 1'b1;
               end
            end
            S_CONVERT: begin
               bcd_d     = {bcd_adj[14:0], shf_q[15]};
               shf_d     = {shf_q[14:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd15) state_d = S_COMMIT;
               if (reload_q) begin
                  dwell_cnt_d = dwell_inc;
                  if (dwell_last && !pri_req) pend_rot_d = 1'b1;
               end
            end
            S_COMMIT: begin
               digit_d     = cap_dec_q ? page_dec : page_hex;
               zero_fill_d = ~cap_dec_q;
               reload_d    = 1'b0;
               pend_rot_d  = 1'b0;
               if ((pend_rot_q || (reload_q && dwell_last)) && !pri_req) begin
                  state_d      = S_IDLE;
                  dwell_cnt_d  = '0;
                  update_cnt_d = '0;
               end else begin
                  state_d = S_DWELL;
                  if (reload_q) dwell_cnt_d = dwell_inc;
               end
            end
            S_DWELL: begin
               if (dwell_last && !pri_req) begin
                  state_d      = S_IDLE;
                  dwell_cnt_d  = '0;
                  update_cnt_d = '0;
               end else if (update_last) begin
                  update_cnt_d = '0;
                  dwell_cnt_d  = dwell_inc;
                  sel_src_d    = active_src_q;
                  reload_d     = 1'b1;
                  state_d      = S_LOAD;
               end else begin
                  dwell_cnt_d  = dwell_inc;
                  update_cnt_d = update_cnt_q + 24'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Releasing the priority request restarts a full dwell on source 0.
      if (pri_fall) begin
         dwell_cnt_d  = '0;
         update_cnt_d = '0;
         pend_rot_d   = 1'b0;
      end
   end

   assign busy_d = (state_d == S_LOAD) || (state_d == S_CONVERT) || (state_d == S_COMMIT);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         active_src_q <= 2'd0;
         sel_src_q    <= 2'd0;
         first_sel_q  <= 1'b1;
         dwell_cnt_q  <= '0;
         update_cnt_q <= '0;
         digit_q      <= '0;
         zero_fill_q  <= 1'b0;
         busy_q       <= 1'b0;
         cap_val_q    <= '0;
         cap_dec_q    <= 1'b0;
         bcd_q        <= '0;
         shf_q        <= '0;
         bit_cnt_q    <= '0;
         pri_q        <= 1'b0;
         reload_q     <= 1'b0;
         pend_rot_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_src_q <= active_src_d;
         sel_src_q    <= sel_src_d;
         first_sel_q  <= first_sel_d;
         dwell_cnt_q  <= dwell_cnt_d;
         update_cnt_q <= update_cnt_d;
         digit_q      <= digit_d;
         zero_fill_q  <= zero_fill_d;
         busy_q       <= busy_d;
         cap_val_q    <= cap_val_d;
         cap_dec_q    <= cap_dec_d;
         bcd_q        <= bcd_d;
         shf_q        <= shf_d;
         bit_cnt_q    <= bit_cnt_d;
         pri_q        <= pri_req;
         reload_q     <= reload_d;
         pend_rot_q   <= pend_rot_d;
      end
   end

   assign digit      = digit_q;
   assign zero_fill  = zero_fill_q;
   assign active_src = active_src_q;
   assign busy       = busy_q;

endmodule
